// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and multiply/divide FSM encoding shared by the execute-stage ALU.
package alu_pkg;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_MFHI  = 4'b1010;
    localparam logic [3:0] OP_MFLO  = 4'b1011;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;
endpackage

// File: rtl/alu_muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle unsigned shift-add multiplier / restoring divider
// owning the HI/LO registers, which change only when an operation completes.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             idle,
    output logic             done,
    output logic [WIDTH-1:0] lo_next,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod, prod_n;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     sum, shl, diff;

    // prod holds {acc, multiplier} for MUL and {remainder, quotient} for DIV
    always_comb begin
        sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        shl    = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        diff   = shl - {1'b0, opnd};
        prod_n = (state == ST_MUL)
               ? (prod[0] ? {sum, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]})
               : (diff[WIDTH] ? {shl[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                              : {diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1});
    end

    assign idle    = (state == ST_IDLE);
    assign done    = !idle && cnt == CNT_W'(1) && !flush;
    assign lo_next = prod_n[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            prod     <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (idle) begin
            if (start) begin
                state <= is_div ? ST_DIV : ST_MUL;
                cnt   <= CNT_W'(WIDTH);
                prod  <= {{WIDTH{1'b0}}, is_div ? a : b};
                opnd  <= is_div ? b : a;
            end
        end else if (flush) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            prod <= prod_n;
            cnt  <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
                state <= ST_IDLE;
                hi    <= prod_n[2*WIDTH-1:WIDTH];
                lo    <= prod_n[WIDTH-1:0];
                if (state == ST_DIV) div_zero <= (opnd == '0);
            end
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with registered single-cycle results and an
// iterative multiply/divide engine that stalls issue through in_ready.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [3:0]       Signal,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] dataOut,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero,
    output logic             busy
);
    localparam int M = WIDTH - 1;

    logic             idle, done, take, is_md, borrow, ov_add, ov_sub, ov_res;
    logic [WIDTH-1:0] hi, lo, lo_next, sum, diff, res;

    assign in_ready = idle;
    assign busy     = !idle;
    // a flush squashes a request arriving in the same cycle
    assign take     = in_valid && in_ready && !flush;
    assign is_md    = (Signal == OP_MULTU) || (Signal == OP_DIVU);

    assign sum           = dataA + dataB;
    assign {borrow, diff} = {1'b0, dataA} - {1'b0, dataB};
    assign ov_add        = (dataA[M] == dataB[M]) && (sum[M] != dataA[M]);
    assign ov_sub        = (dataA[M] != dataB[M]) && (diff[M] != dataA[M]);

    always_comb begin
        res = (Signal == OP_AND)  ? dataA & dataB
            : (Signal == OP_OR)   ? dataA | dataB
            : (Signal == OP_ADD)  ? sum
            : (Signal == OP_SUB)  ? diff
            : (Signal == OP_SLT)  ? {{M{1'b0}}, diff[M] ^ ov_sub}
            : (Signal == OP_SLTU) ? {{M{1'b0}}, borrow}
            : (Signal == OP_MFHI) ? hi
            : (Signal == OP_MFLO) ? lo
            : '0;
        ov_res = (Signal == OP_ADD) ? ov_add : (Signal == OP_SUB) ? ov_sub : 1'b0;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (take && is_md),
        .is_div   (Signal == OP_DIVU),
        .a        (dataA),
        .b        (dataB),
        .flush    (flush),
        .idle     (idle),
        .done     (done),
        .lo_next  (lo_next),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dataOut   <= '0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
        end else begin
            out_valid <= done || (take && !is_md);
            if (done) begin
                dataOut  <= lo_next;
                zero     <= (lo_next == '0);
                overflow <= 1'b0;
            end else if (take && !is_md) begin
                dataOut  <= res;
                zero     <= (res == '0);
                overflow <= ov_res;
            end
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vector table for single-cycle ops plus hand-written
// multiply/divide, flush and reset sequences at WIDTH=32 and WIDTH=8.
module tb_alu_muldiv;
    logic        clk = 1'b0, rst_n, in_valid, flush;
    logic [3:0]  sig;
    logic [31:0] a, b;
    logic        in_ready, out_valid, zero, overflow, div_zero, busy;
    logic [31:0] data_out;
    logic        v8, in_ready8, out_valid8, zero8, overflow8, div_zero8, busy8;
    logic [3:0]  s8;
    logic [7:0]  a8, b8, data_out8;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .dataA(a), .dataB(b), .Signal(sig), .flush(flush), .out_valid(out_valid),
        .dataOut(data_out), .zero(zero), .overflow(overflow), .div_zero(div_zero), .busy(busy)
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(in_ready8),
        .dataA(a8), .dataB(b8), .Signal(s8), .flush(flush), .out_valid(out_valid8),
        .dataOut(data_out8), .zero(zero8), .overflow(overflow8), .div_zero(div_zero8), .busy(busy8)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] x, y, res;
        logic        ov;
    } vec_t;
    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic single(input string nm, input logic [3:0] op, input logic [31:0] x, y, exp);
        sig = op; a = x; b = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({nm, " out_valid"}, 32'(out_valid), 32'd1);
        chk({nm, " dataOut"}, data_out, exp);
    endtask

    task automatic md(input string nm, input logic [3:0] op, input logic [31:0] x, y, exp_lo);
        int n;
        sig = op; a = x; b = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk({nm, " in_ready low"}, 32'(in_ready), 32'd0);
        chk({nm, " busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 100) begin
            step();
            n++;
        end
        chk({nm, " latency"}, 32'(n), 32'd32);
        chk({nm, " LO"}, data_out, exp_lo);
        chk({nm, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n, seen;
        vecs[0]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
        vecs[1]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
        vecs[2]  = '{4'b0111, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0};
        vecs[3]  = '{4'b0101, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0};
        vecs[4]  = '{4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
        vecs[5]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        vecs[6]  = '{4'b0001, 32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF, 1'b0};
        vecs[7]  = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
        vecs[8]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        vecs[9]  = '{4'b0101, 32'h00000001, 32'h80000000, 32'h00000001, 1'b0};
        vecs[10] = '{4'b0111, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[11] = '{4'b0011, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0};
        vecs[12] = '{4'b0010, 32'h00001234, 32'h00000001, 32'h00001235, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; sig = '0; a = '0; b = '0;
        v8 = 1'b0; s8 = '0; a8 = '0; b8 = '0;
        step(); step();
        chk("reset dataOut", data_out, 32'd0);
        chk("reset zero", 32'(zero), 32'd1);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset div_zero", 32'(div_zero), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        step();

        // back-to-back single-cycle ops, one result per edge
        for (int i = 0; i < 13; i++) begin
            sig = vecs[i].op; a = vecs[i].x; b = vecs[i].y; in_valid = 1'b1;
            step();
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d dataOut", i), data_out, vecs[i].res);
            chk($sformatf("vec%0d zero", i), 32'(zero), 32'(vecs[i].res == 32'd0));
            chk($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].ov));
            chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        chk("idle out_valid", 32'(out_valid), 32'd0);
        chk("idle holds dataOut", data_out, 32'h00001235);

        md("multu max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        single("mfhi multu", 4'b1010, 32'd0, 32'd0, 32'hFFFFFFFE);
        single("mflo multu", 4'b1011, 32'd0, 32'd0, 32'h00000001);
        md("divu 100/7", 4'b1001, 32'd100, 32'd7, 32'd14);
        chk("divu 100/7 div_zero", 32'(div_zero), 32'd0);
        single("mfhi 100/7", 4'b1010, 32'd0, 32'd0, 32'd2);
        md("divu 9/0", 4'b1001, 32'd9, 32'd0, 32'hFFFFFFFF);
        chk("divu 9/0 div_zero", 32'(div_zero), 32'd1);
        single("mfhi 9/0", 4'b1010, 32'd0, 32'd0, 32'd9);
        md("divu 10/3", 4'b1001, 32'd10, 32'd3, 32'd3);
        chk("divu 10/3 div_zero clear", 32'(div_zero), 32'd0);

        // flush at cycle 10 of a multiply: nothing retires, HI/LO keep 1/3
        sig = 4'b1000; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush out_valid", 32'(out_valid), 32'd0);
        chk("flush in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            seen += int'(out_valid);
        end
        chk("flush no late out_valid", 32'(seen), 32'd0);
        single("mflo after flush", 4'b1011, 32'd0, 32'd0, 32'd3);
        single("mfhi after flush", 4'b1010, 32'd0, 32'd0, 32'd1);
        sig = 4'b0010; a = 32'd2; b = 32'd3; in_valid = 1'b1;
        step();
        chk("b2b add a out_valid", 32'(out_valid), 32'd1);
        chk("b2b add a", data_out, 32'd5);
        a = 32'd7;
        step();
        in_valid = 1'b0;
        chk("b2b add b", data_out, 32'd10);
        sig = 4'b0010; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush squashes accept", 32'(out_valid), 32'd0);
        chk("squashed dataOut held", data_out, 32'd10);

        // asynchronous reset in the middle of a divide
        md("divu 5/0", 4'b1001, 32'd5, 32'd0, 32'hFFFFFFFF);
        sig = 4'b1001; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pre-reset busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async rst dataOut", data_out, 32'd0);
        chk("async rst zero", 32'(zero), 32'd1);
        chk("async rst div_zero", 32'(div_zero), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
        chk("async rst busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        single("mfhi after rst", 4'b1010, 32'd0, 32'd0, 32'd0);
        single("mflo after rst", 4'b1011, 32'd0, 32'd0, 32'd0);
        chk("mflo after rst zero", 32'(zero), 32'd1);

        // WIDTH=8 multiply: 0xFF*0xFF = 0xFE01
        s8 = 4'b1000; a8 = 8'hFF; b8 = 8'hFF; v8 = 1'b1;
        step();
        v8 = 1'b0;
        chk("w8 in_ready low", 32'(in_ready8), 32'd0);
        n = 0;
        while (!out_valid8 && n < 50) begin
            step();
            n++;
        end
        chk("w8 latency", 32'(n), 32'd8);
        chk("w8 LO", 32'(data_out8), 32'h01);
        s8 = 4'b1010; v8 = 1'b1;
        step();
        v8 = 1'b0;
        chk("w8 mfhi valid", 32'(out_valid8), 32'd1);
        chk("w8 HI", 32'(data_out8), 32'hFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised next-generation execute-stage ALU for the pipelined MIPS-style CPU.
- Keeps the existing AND/OR/ADD/SUB/SLT operations and adds overflow-correct signed SLT, unsigned SLTU, and an overflow flag.
- Adds an iterative unsigned multiply/divide engine with HI/LO registers.
- Results are registered. Multi-cycle operations stall the pipeline through a valid/ready handshake.

Parameters:
- WIDTH, 32, datapath width in bits (≥4, even).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request from ID/EX.
- in_ready  out  1  engine can accept a request this cycle.
- dataA  in  WIDTH  operand a.
- dataB  in  WIDTH  operand b.
- Signal  in  4  opcode (see Behaviour).
- flush  in  1  abort any in-flight multiply/divide (branch/exception).
- out_valid  out  1  one-cycle pulse, dataOut valid.
- dataOut  out  WIDTH  registered result.
- zero  out  1  registered (result == 0).
- overflow  out  1  registered signed overflow for ADD/SUB.
- div_zero  out  1  registered: last DIVU had a zero divisor.
- busy  out  1  multiply/divide iterating (= !in_ready).

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 0101 SLTU.
  - 1000 MULTU, 1001 DIVU, 1010 MFHI, 1011 MFLO.
  - Any other opcode returns 0 with out_valid=1.
- Reset values: dataOut=0, zero=1, overflow=0, div_zero=0, out_valid=0, in_ready=1, busy=0, HI=LO=0, state=IDLE, counter=0.
- Accept: a request is taken when in_valid && in_ready. Inputs are not sampled otherwise.
- Single-cycle ops (logic, ADD, SUB, SLT, SLTU, MFHI, MFLO): out_valid=1 on the next edge with registered outputs. Throughput is 1 per cycle. in_ready stays 1.
- ADD/SUB arithmetic:
  - WIDTH-bit wraparound.
  - overflow = (signs of a and effective b equal) && (result sign differs).
  - overflow=0 for all other ops.
- SLT = (a−b)[MSB] XOR overflow, zero-extended to WIDTH, so it is correct at extremes. SLTU = borrow out of a−b.
- zero reflects the registered dataOut for every op.
- FSM states:
  - IDLE: accepting MULTU/DIVU → MUL or DIV; counter=WIDTH; in_ready=0.
  - MUL: shift-add, one bit per cycle. {HI,LO} accumulates the 2·WIDTH product.
  - DIV: restoring divide, one bit per cycle. LO=quotient, HI=remainder.
  - MUL/DIV: counter decrements each cycle. At counter reaching 1, next edge → IDLE with out_valid=1 and dataOut=new LO.
- Multiply/divide latency: accept edge + WIDTH cycles, so out_valid is WIDTH+1 edges after accept (33 at WIDTH=32).
- HI/LO update only on completion. During iteration MFHI/MFLO cannot be issued (in_ready=0).
- DIVU with dataB=0: completes with the same latency. HI=dataA, LO=all ones, div_zero=1. Any other DIVU completion clears div_zero.
- flush:
  - While MUL/DIV: return to IDLE next edge, no out_valid, HI/LO unchanged, in_ready=1 next cycle.
  - flush in IDLE also squashes a same-cycle accept: no out_valid.
- Asynchronous reset mid-operation: immediate return to all reset values. The partial result is discarded.
- out_valid has no back-pressure. The consumer must take dataOut in the pulse cycle. dataOut holds its value until the next result.

Decomposition:
- Shared package alu_pkg holds:
  - opcode localparams (OP_AND..OP_MFLO);
  - FSM state encoding (ST_IDLE, ST_MUL, ST_DIV).
- One natural sub-module: muldiv_iter, which holds the FSM, counter, shift/subtract datapath, and HI/LO.
- The top holds the single-cycle ALU, the result mux and the output registers.

Test Plan:
- ADD 0x7FFFFFFF+1 → dataOut=0x80000000, overflow=1, out_valid next cycle. SUB 5−5 → 0, zero=1.
- SLT a=0x80000000, b=1 → 1. SLTU same operands → 0. SLT a=0x7FFFFFFF, b=0xFFFFFFFF → 0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → in_ready low for 32 cycles, out_valid at edge 33, LO=0x00000001, then MFHI → 0xFFFFFFFE.
- DIVU 100/7 → LO=14, MFHI → 2. DIVU 9/0 → LO=0xFFFFFFFF, HI=9, div_zero=1.
- Start MULTU, assert flush at cycle 10 → no out_valid, MFLO returns the prior LO, back-to-back ADD accepted.
- Drop rst_n at cycle 5 of DIVU → outputs at reset values immediately, in_ready=1, HI=LO=0. Repeat at WIDTH=8: MULTU 0xFF×0xFF → LO=0x01, HI=0xFE after 9 edges.
